// File: rtl/mis_stimulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mis_stimulus_sequencer
// Purpose  : Sweeps the skew between two chain inputs (A1/A2) over a signed
//            range, repeats each skew a configurable number of times, and
//            reports whether the chain output settled to the expected level.
// Revision : 1.0 - initial release
// ============================================================================
module mis_stimulus_sequencer #(
  parameter int SKEW_W     = 5,
  parameter int SETTLE_CYC = 8,
  parameter int REP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              dir,
  input  logic [SKEW_W-1:0] skew_min,
  input  logic [SKEW_W-1:0] skew_max,
  input  logic [REP_W-1:0]  rep_cnt,
  output logic              drv_a1,
  output logic              drv_a2,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              smp_valid,
  output logic [SKEW_W-1:0] smp_skew,
  output logic              smp_ok,
  output logic              cfg_err
);

  // Counter must hold both the settle length and the largest |skew|.
  localparam int CNT_W = ((SKEW_W + 1) > ($clog2(SETTLE_CYC) + 1)) ?
                         (SKEW_W + 1) : ($clog2(SETTLE_CYC) + 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_LAUNCH  = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_NEXT    = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t state, state_nxt;

  // Skew is carried one bit wider so the sweep end and |min| never wrap.
  logic signed [SKEW_W:0] skew_q, skew_nxt;
  logic signed [SKEW_W:0] skew_max_q, skew_max_nxt;
  logic signed [SKEW_W:0] smin_ext, smax_ext;
  logic [REP_W-1:0]       rep_q, rep_nxt;
  logic [REP_W-1:0]       trial_q, trial_nxt;
  logic                   dir_q, dir_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt, cnt_inc;
  logic [SKEW_W:0]        mag;
  logic [CNT_W-1:0]       mag_c, t1, t2;
  logic                   neg, init_lvl, fin_lvl;

  logic                   a1_nxt, a2_nxt, busy_nxt, done_nxt, vld_nxt, ok_nxt, cfg_err_nxt;
  logic [SKEW_W-1:0]      smp_skew_nxt;

  assign smin_ext = {skew_min[SKEW_W-1], skew_min};
  assign smax_ext = {skew_max[SKEW_W-1], skew_max};
  assign neg      = skew_q[SKEW_W];
  assign mag      = neg ? (-skew_q) : skew_q;
  assign mag_c    = CNT_W'(mag);
  // t1/t2: launch cycle at which A1/A2 reach their final level.
  assign t1       = neg ? mag_c : '0;
  assign t2       = neg ? '0 : mag_c;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign init_lvl = dir_q;
  assign fin_lvl  = ~dir_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt_q;
    skew_nxt     = skew_q;
    skew_max_nxt = skew_max_q;
    rep_nxt      = rep_q;
    trial_nxt    = trial_q;
    dir_nxt      = dir_q;
    a1_nxt       = drv_a1;
    a2_nxt       = drv_a2;
    cfg_err_nxt  = cfg_err;
    done_nxt     = 1'b0;
    vld_nxt      = 1'b0;
    ok_nxt       = smp_ok;
    smp_skew_nxt = smp_skew;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          dir_nxt      = dir;
          skew_nxt     = smin_ext;
          skew_max_nxt = smax_ext;
          rep_nxt      = rep_cnt;
          trial_nxt    = '0;
          cnt_nxt      = '0;
          if (smin_ext > smax_ext) begin
            cfg_err_nxt = 1'b1;
            state_nxt   = S_FIN;
          end else begin
            cfg_err_nxt = 1'b0;
            state_nxt   = S_ARM;
            a1_nxt      = dir;
            a2_nxt      = dir;
          end
        end
      end
      S_ARM: begin
        if (cnt_q == SET_LAST) begin
          state_nxt = S_LAUNCH;
          cnt_nxt   = '0;
          a1_nxt    = (t1 == '0) ? fin_lvl : init_lvl;
          a2_nxt    = (t2 == '0) ? fin_lvl : init_lvl;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_LAUNCH: begin
        if (cnt_q == mag_c) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          a1_nxt  = (cnt_inc >= t1) ? fin_lvl : init_lvl;
          a2_nxt  = (cnt_inc >= t2) ? fin_lvl : init_lvl;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_nxt = S_CAPTURE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_CAPTURE: begin
        state_nxt    = S_NEXT;
        vld_nxt      = 1'b1;
        ok_nxt       = (dut_out == fin_lvl);
        smp_skew_nxt = skew_q[SKEW_W-1:0];
      end
      S_NEXT: begin
        cnt_nxt = '0;
        if (trial_q < rep_q) begin
          trial_nxt = trial_q + REP_W'(1);
          state_nxt = S_ARM;
          a1_nxt    = init_lvl;
          a2_nxt    = init_lvl;
        end else if (skew_q == skew_max_q) begin
          state_nxt = S_FIN;
        end else begin
          skew_nxt  = skew_q + (SKEW_W+1)'(1);
          trial_nxt = '0;
          state_nxt = S_ARM;
          a1_nxt    = init_lvl;
          a2_nxt    = init_lvl;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over everything, including a capture in the same cycle.
    if (abort && (state != S_IDLE) && (state != S_FIN)) begin
      state_nxt    = S_FIN;
      vld_nxt      = 1'b0;
      ok_nxt       = smp_ok;
      smp_skew_nxt = smp_skew;
    end

    // Drives rest at 0 whenever the sweep is finishing or idle.
    if ((state_nxt == S_FIN) || (state_nxt == S_IDLE)) begin
      a1_nxt = 1'b0;
      a2_nxt = 1'b0;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, datapath and output registers; reset drops the drives immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt_q      <= '0;
      skew_q     <= '0;
      skew_max_q <= '0;
      rep_q      <= '0;
      trial_q    <= '0;
      dir_q      <= 1'b0;
      drv_a1     <= 1'b0;
      drv_a2     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      smp_valid  <= 1'b0;
      smp_skew   <= '0;
      smp_ok     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt_q      <= cnt_nxt;
      skew_q     <= skew_nxt;
      skew_max_q <= skew_max_nxt;
      rep_q      <= rep_nxt;
      trial_q    <= trial_nxt;
      dir_q      <= dir_nxt;
      drv_a1     <= a1_nxt;
      drv_a2     <= a2_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      smp_valid  <= vld_nxt;
      smp_skew   <= smp_skew_nxt;
      smp_ok     <= ok_nxt;
      cfg_err    <= cfg_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mis_stimulus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mis_stimulus_sequencer
// Purpose  : Self-checking bench for mis_stimulus_sequencer. A timeline model
//            builds the expected per-cycle outputs of a sweep from the phase
//            durations; table rows, random sweeps and hand sequences use it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mis_stimulus_sequencer;

  localparam int SKEW_W     = 5;
  localparam int SETTLE_CYC = 8;
  localparam int REP_W      = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              dir = 1'b0;
  logic              dut_out = 1'b0;
  logic [SKEW_W-1:0] skew_min = '0;
  logic [SKEW_W-1:0] skew_max = '0;
  logic [REP_W-1:0]  rep_cnt = '0;
  logic              drv_a1, drv_a2, busy, done, smp_valid, smp_ok, cfg_err;
  logic [SKEW_W-1:0] smp_skew;

  int total = 0;
  int bad   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  mis_stimulus_sequencer #(
    .SKEW_W(SKEW_W), .SETTLE_CYC(SETTLE_CYC), .REP_W(REP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir(dir),
    .skew_min(skew_min), .skew_max(skew_max), .rep_cnt(rep_cnt),
    .drv_a1(drv_a1), .drv_a2(drv_a2), .dut_out(dut_out),
    .busy(busy), .done(done), .smp_valid(smp_valid), .smp_skew(smp_skew),
    .smp_ok(smp_ok), .cfg_err(cfg_err)
  );

  typedef struct {
    logic a1, a2, bsy, dn, vld, cap;
    int   skew;
  } cyc_t;

  typedef struct {
    logic d;
    int   smin, smax, rep, ab, nval;
    logic cfg;
  } vec_t;

  cyc_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(expv));
    end
  endtask

  task automatic push(input logic a1, input logic a2, input logic bsy, input logic dn,
                      input logic vld, input logic cap, input int skew);
    cyc_t e;
    e.a1 = a1; e.a2 = a2; e.bsy = bsy; e.dn = dn; e.vld = vld; e.cap = cap; e.skew = skew;
    exp_q.push_back(e);
  endtask

  // Expected timeline, one entry per cycle starting the cycle after start.
  task automatic build_model(input logic d, input int smin, input int smax, input int rep);
    logic ini, fin;
    ini = d;
    fin = ~d;
    exp_q.delete();
    if (smin <= smax) begin
      for (int s = smin; s <= smax; s++) begin
        for (int t = 0; t <= rep; t++) begin
          int m, k1, k2;
          m  = (s < 0) ? -s : s;
          k1 = (s < 0) ? m : 0;
          k2 = (s < 0) ? 0 : m;
          repeat (SETTLE_CYC) push(ini, ini, 1, 0, 0, 0, 0);
          for (int k = 0; k <= m; k++)
            push((k >= k1) ? fin : ini, (k >= k2) ? fin : ini, 1, 0, 0, 0, 0);
          repeat (SETTLE_CYC) push(fin, fin, 1, 0, 0, 0, 0);
          push(fin, fin, 1, 0, 0, 1, 0);
          push(fin, fin, 1, 0, 1, 0, s);
        end
      end
    end
    push(0, 0, 1, 0, 0, 0, 0);
    push(0, 0, 0, 1, 0, 0, 0);
  endtask

  // Runs one sweep from idle; call at a falling edge.
  task automatic run_sweep(input logic d, input int smin, input int smax, input int rep,
                           input int abort_at, output int nval, output int model_nval);
    int   ab;
    logic cap_val, illegal;
    cyc_t e;
    build_model(d, smin, smax, rep);
    ab = abort_at;
    if (ab >= 0 && ab < exp_q.size() - 2) begin
      while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
      push(0, 0, 1, 0, 0, 0, 0);
      push(0, 0, 0, 1, 0, 0, 0);
    end else begin
      ab = -1;
    end
    model_nval = 0;
    foreach (exp_q[j]) if (exp_q[j].vld) model_nval++;
    illegal  = (smin > smax);
    dir      = d;
    skew_min = smin[SKEW_W-1:0];
    skew_max = smax[SKEW_W-1:0];
    rep_cnt  = rep[REP_W-1:0];
    abort    = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    nval    = 0;
    cap_val = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      chk("drv_a1", drv_a1, e.a1);
      chk("drv_a2", drv_a2, e.a2);
      chk("busy", busy, e.bsy);
      chk("done", done, e.dn);
      chk("smp_valid", smp_valid, e.vld);
      chk("cfg_err", cfg_err, illegal);
      if (smp_valid) nval++;
      if (e.vld) begin
        chk("smp_skew", $signed(smp_skew), e.skew);
        chk("smp_ok", smp_ok, (cap_val == ~d));
      end
      dut_out = 1'($urandom % 2);
      if (e.cap) cap_val = dut_out;
      abort    = (i == ab);
      start    = (i < exp_q.size() - 1) && ($urandom % 6 == 0);
      dir      = 1'($urandom);
      skew_min = SKEW_W'($urandom);
      skew_max = SKEW_W'($urandom);
      rep_cnt  = REP_W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t tbl[7];
  int   nv, mv;

  initial begin
    tbl[0] = '{d:0, smin:3,   smax:3,   rep:0, ab:-1, nval:1,  cfg:0};
    tbl[1] = '{d:1, smin:-2,  smax:2,   rep:1, ab:-1, nval:10, cfg:0};
    tbl[2] = '{d:0, smin:5,   smax:-5,  rep:0, ab:-1, nval:0,  cfg:1};
    tbl[3] = '{d:0, smin:-16, smax:15,  rep:0, ab:-1, nval:32, cfg:0};
    tbl[4] = '{d:0, smin:0,   smax:3,   rep:0, ab:32, nval:1,  cfg:0};
    tbl[5] = '{d:1, smin:15,  smax:15,  rep:2, ab:-1, nval:3,  cfg:0};
    tbl[6] = '{d:1, smin:-16, smax:-16, rep:0, ab:-1, nval:1,  cfg:0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst drv_a1", drv_a1, 0);
    chk("rst drv_a2", drv_a2, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst smp_valid", smp_valid, 0);
    chk("rst smp_ok", smp_ok, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst smp_skew", smp_skew, 0);
    rst_n = 1'b1;

    // Table-driven sweeps; the first start lands on the first edge after reset.
    for (int r = 0; r < 7; r++) begin
      run_sweep(tbl[r].d, tbl[r].smin, tbl[r].smax, tbl[r].rep, tbl[r].ab, nv, mv);
      chk("tbl nvalid", nv, tbl[r].nval);
      chk("tbl cfg_err", cfg_err, tbl[r].cfg);
    end

    // Start together with abort in idle is ignored; abort alone does nothing.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle start+abort busy", busy, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", busy, 0);
    chk("idle abort done", done, 0);
    chk("idle abort drv_a1", drv_a1, 0);

    // Reset pulsed mid-launch: drives drop at once, no done pulse.
    dir = 1'b1; skew_min = 5'd5; skew_max = 5'd5; rep_cnt = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE_CYC + 2) @(negedge clk);
    chk("launch drv_a1", drv_a1, 0);
    chk("launch drv_a2", drv_a2, 1);
    rst_n = 1'b0;
    #1;
    chk("async rst drv_a1", drv_a1, 0);
    chk("async rst drv_a2", drv_a2, 0);
    chk("async rst busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst no done", done, 0);
    end
    rst_n = 1'b1;
    run_sweep(0, -1, 1, 0, -1, nv, mv);
    chk("post-reset nvalid", nv, 3);

    // Random sweeps checked against the timeline model.
    for (int n = 0; n < 6; n++) begin
      int smin, smax, rep, ab;
      logic d;
      d    = 1'($urandom);
      smin = int'($urandom_range(31, 0)) - 16;
      smax = smin + int'($urandom_range(3, 0)) - (($urandom % 5 == 0) ? 4 : 0);
      if (smax > 15) smax = 15;
      if (smax < -16) smax = -16;
      rep  = int'($urandom_range(2, 0));
      ab   = ($urandom % 3 == 0) ? int'($urandom_range(60, 0)) : -1;
      run_sweep(d, smin, smax, rep, ab, nv, mv);
      chk("rand nvalid", nv, mv);
      chk("rand cfg_err", cfg_err, (smin > smax));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
